// File: rtl/pcie_mmio_target.sv
// Single-DW MMIO completer between the 7-series PCIe 64-bit AXI-S RX/TX and a BAR0 register file.
// Optional `PCIE_MMIO_UR_EN: unsupported MRd requests get an Unsupported Request Cpl after drain.
module pcie_mmio_target #(
    parameter int unsigned NUM_REGS = 8,
    parameter logic [31:0] ID_VALUE = 32'h4B433035
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [63:0] m_axis_rx_tdata,
    input  logic [7:0]  m_axis_rx_tkeep,
    input  logic        m_axis_rx_tlast,
    input  logic        m_axis_rx_tvalid,
    output logic        m_axis_rx_tready,
    input  logic [21:0] m_axis_rx_tuser,
    output logic [63:0] s_axis_tx_tdata,
    output logic [7:0]  s_axis_tx_tkeep,
    output logic        s_axis_tx_tlast,
    output logic        s_axis_tx_tvalid,
    input  logic        s_axis_tx_tready,
    input  logic [15:0] cfg_completer_id,
    output logic [7:0]  led
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        RX_HDR0,
        RX_HDR1,
        RX_DATA,
        RX_CPL,
        RX_DRAIN
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_BEAT0,
        TX_BEAT1
    } tx_state_t;

    rx_state_t rx_state;
    tx_state_t tx_state;

    logic [31:0] regs [NUM_REGS];

    logic             hdr_is_wr;
    logic             hdr_is64;
    logic             hdr_ur;
    logic [3:0]       hdr_be;
    logic [15:0]      hdr_req_id;
    logic [7:0]       hdr_tag;
    logic [2:0]       hdr_tc;
    logic [1:0]       hdr_attr;
    logic [IDX_W-1:0] hdr_idx;
    logic [4:0]       hdr_lo_addr;
    logic [31:0]      rd_data;
    logic             cpl_go;

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // Beat-0 decode; only meaningful while in RX_HDR0.
    logic [6:0] rx_ft;
    logic       rx_is_rd;
    logic       rx_is_wr;
    logic       rx_supported;
    logic       rx_ur;
    logic       rx_accept;

    assign rx_accept    = m_axis_rx_tvalid & m_axis_rx_tready;
    assign rx_ft        = m_axis_rx_tdata[30:24];
    assign rx_is_rd     = (rx_ft == 7'h00) || (rx_ft == 7'h20);
    assign rx_is_wr     = (rx_ft == 7'h40) || (rx_ft == 7'h60);
    assign rx_supported = (rx_is_rd || rx_is_wr) && (m_axis_rx_tdata[9:0] == 10'd1)
                          && m_axis_rx_tuser[2];
`ifdef PCIE_MMIO_UR_EN
    assign rx_ur        = rx_is_rd && !rx_supported;
`else
    assign rx_ur        = 1'b0;
`endif

    // Beat-1 address: DW2 for 3DW headers, DW3 (low address) for 4DW headers.
    logic [31:0]      rx_addr;
    logic [IDX_W-1:0] rx_idx;
    logic [31:0]      rd_value;

    assign rx_addr  = hdr_is64 ? m_axis_rx_tdata[63:32] : m_axis_rx_tdata[31:0];
    assign rx_idx   = rx_addr[IDX_W+1:2];
    assign rd_value = (rx_idx == LAST_IDX) ? ID_VALUE : regs[rx_idx];

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_dw;
    logic [31:0]      wr_swapped;

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = hdr_idx;
        wr_dw  = m_axis_rx_tdata[31:0];
        if (rx_accept) begin
            if (rx_state == RX_HDR1 && hdr_is_wr && !hdr_is64) begin
                wr_en  = 1'b1;
                wr_idx = rx_idx;
                wr_dw  = m_axis_rx_tdata[63:32];
            end else if (rx_state == RX_DATA) begin
                wr_en  = 1'b1;
            end
        end
    end

    assign wr_swapped = bswap(wr_dw);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_idx != LAST_IDX) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (hdr_be[b]) begin
                    regs[wr_idx][8*b +: 8] <= wr_swapped[8*b +: 8];
                end
            end
        end
    end

    assign led = regs[0][7:0];

    logic cpl_done;
    assign cpl_done = (tx_state == TX_BEAT1) && s_axis_tx_tready;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_state         <= RX_HDR0;
            m_axis_rx_tready <= 1'b0;
            hdr_is_wr        <= 1'b0;
            hdr_is64         <= 1'b0;
            hdr_ur           <= 1'b0;
            hdr_be           <= '0;
            hdr_req_id       <= '0;
            hdr_tag          <= '0;
            hdr_tc           <= '0;
            hdr_attr         <= '0;
            hdr_idx          <= '0;
            hdr_lo_addr      <= '0;
            rd_data          <= '0;
            cpl_go           <= 1'b0;
        end else begin
            cpl_go           <= 1'b0;
            m_axis_rx_tready <= 1'b1;
            case (rx_state)
                RX_HDR0: begin
                    if (rx_accept) begin
                        hdr_is_wr  <= rx_is_wr;
                        hdr_is64   <= rx_ft[5];
                        hdr_ur     <= rx_ur;
                        hdr_be     <= m_axis_rx_tdata[35:32];
                        hdr_req_id <= m_axis_rx_tdata[63:48];
                        hdr_tag    <= m_axis_rx_tdata[47:40];
                        hdr_tc     <= m_axis_rx_tdata[22:20];
                        hdr_attr   <= m_axis_rx_tdata[13:12];
                        if (m_axis_rx_tlast) begin
                            rx_state <= RX_HDR0;
                        end else if (rx_supported) begin
                            rx_state <= RX_HDR1;
                        end else begin
                            rx_state <= RX_DRAIN;
                        end
                    end
                end
                RX_HDR1: begin
                    if (rx_accept) begin
                        hdr_idx     <= rx_idx;
                        hdr_lo_addr <= rx_addr[6:2];
                        if (!hdr_is_wr) begin
                            rd_data          <= rd_value;
                            cpl_go           <= 1'b1;
                            rx_state         <= RX_CPL;
                            m_axis_rx_tready <= 1'b0;
                        end else if (hdr_is64) begin
                            rx_state <= RX_DATA;
                        end else begin
                            rx_state <= m_axis_rx_tlast ? RX_HDR0 : RX_DRAIN;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_accept) begin
                        rx_state <= m_axis_rx_tlast ? RX_HDR0 : RX_DRAIN;
                    end
                end
                RX_DRAIN: begin
                    if (rx_accept && m_axis_rx_tlast) begin
                        if (hdr_ur) begin
                            cpl_go           <= 1'b1;
                            rx_state         <= RX_CPL;
                            m_axis_rx_tready <= 1'b0;
                        end else begin
                            rx_state <= RX_HDR0;
                        end
                    end
                end
                RX_CPL: begin
                    if (cpl_done) begin
                        rx_state <= RX_HDR0;
                    end else begin
                        m_axis_rx_tready <= 1'b0;
                    end
                end
                default: rx_state <= RX_HDR0;
            endcase
        end
    end

    // Completion fields; UR variant carries no data, zero length and byte count.
    logic [31:0] cpl_dw0;
    logic [31:0] cpl_dw1;
    logic [31:0] cpl_dw2;
    logic [31:0] cpl_payload;

    assign cpl_dw0     = {1'b0, (hdr_ur ? 7'h0A : 7'h4A), 1'b0, hdr_tc, 4'b0000,
                          2'b00, hdr_attr, 2'b00, (hdr_ur ? 10'd0 : 10'd1)};
    assign cpl_dw1     = {cfg_completer_id, (hdr_ur ? 3'b001 : 3'b000), 1'b0,
                          (hdr_ur ? 12'd0 : 12'd4)};
    assign cpl_dw2     = {hdr_req_id, hdr_tag, 1'b0,
                          (hdr_ur ? 7'd0 : {hdr_lo_addr, 2'b00})};
    assign cpl_payload = hdr_ur ? '0 : bswap(rd_data);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_state         <= TX_IDLE;
            s_axis_tx_tvalid <= 1'b0;
            s_axis_tx_tlast  <= 1'b0;
            s_axis_tx_tdata  <= '0;
            s_axis_tx_tkeep  <= '1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (cpl_go) begin
                        s_axis_tx_tdata  <= {cpl_dw1, cpl_dw0};
                        s_axis_tx_tvalid <= 1'b1;
                        s_axis_tx_tlast  <= 1'b0;
                        s_axis_tx_tkeep  <= '1;
                        tx_state         <= TX_BEAT0;
                    end
                end
                TX_BEAT0: begin
                    if (s_axis_tx_tready) begin
                        s_axis_tx_tdata <= {cpl_payload, cpl_dw2};
                        s_axis_tx_tlast <= 1'b1;
                        s_axis_tx_tkeep <= hdr_ur ? 8'h0F : 8'hFF;
                        tx_state        <= TX_BEAT1;
                    end
                end
                TX_BEAT1: begin
                    if (s_axis_tx_tready) begin
                        s_axis_tx_tdata  <= '0;
                        s_axis_tx_tvalid <= 1'b0;
                        s_axis_tx_tlast  <= 1'b0;
                        s_axis_tx_tkeep  <= '1;
                        tx_state         <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{m_axis_rx_tkeep, m_axis_rx_tuser[21:3], m_axis_rx_tuser[1:0], rx_addr};

endmodule

// File: tb/tb_pcie_mmio_target.sv
// Directed-vector bench for pcie_mmio_target: MMIO writes/reads, drains, TX backpressure, mid-TLP reset.
module tb_pcie_mmio_target;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [63:0] m_axis_rx_tdata;
    logic [7:0]  m_axis_rx_tkeep;
    logic        m_axis_rx_tlast;
    logic        m_axis_rx_tvalid;
    logic        m_axis_rx_tready;
    logic [21:0] m_axis_rx_tuser;
    logic [63:0] s_axis_tx_tdata;
    logic [7:0]  s_axis_tx_tkeep;
    logic        s_axis_tx_tlast;
    logic        s_axis_tx_tvalid;
    logic        s_axis_tx_tready;
    logic [15:0] cfg_completer_id;
    logic [7:0]  led;

    always #5 sys_clk = ~sys_clk;

    pcie_mmio_target #(.NUM_REGS(8), .ID_VALUE(32'h4B433035)) dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .m_axis_rx_tdata  (m_axis_rx_tdata),
        .m_axis_rx_tkeep  (m_axis_rx_tkeep),
        .m_axis_rx_tlast  (m_axis_rx_tlast),
        .m_axis_rx_tvalid (m_axis_rx_tvalid),
        .m_axis_rx_tready (m_axis_rx_tready),
        .m_axis_rx_tuser  (m_axis_rx_tuser),
        .s_axis_tx_tdata  (s_axis_tx_tdata),
        .s_axis_tx_tkeep  (s_axis_tx_tkeep),
        .s_axis_tx_tlast  (s_axis_tx_tlast),
        .s_axis_tx_tvalid (s_axis_tx_tvalid),
        .s_axis_tx_tready (s_axis_tx_tready),
        .cfg_completer_id (cfg_completer_id),
        .led              (led)
    );

`ifdef PCIE_MMIO_UR_EN
    localparam logic UR_BUILD = 1'b1;
`else
    localparam logic UR_BUILD = 1'b0;
`endif

    localparam logic [63:0] CPLD_B0 = 64'h01000004_4A000001;
    localparam logic [63:0] UR_B0   = 64'h01002000_0A000000;

    typedef struct {
        logic [6:0]  ft;
        logic [9:0]  len;
        logic        bar;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [7:0]  tag;
        logic [15:0] req;
        logic        exp_cpl;
        logic [63:0] exp_b0;
        logic [63:0] exp_b1;
        logic [7:0]  exp_k1;
        logic [7:0]  exp_led;
    } vec_t;

    int unsigned n_applied = 0;
    int unsigned n_miscompares = 0;

    function automatic vec_t mk(input logic [6:0] ft, input logic [9:0] len, input logic bar,
                                input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data,
                                input logic [7:0] tag, input logic [15:0] req, input logic cpl,
                                input logic [63:0] b0, input logic [63:0] b1, input logic [7:0] k1,
                                input logic [7:0] led_v);
        vec_t v;
        v.ft = ft; v.len = len; v.bar = bar; v.addr = addr; v.be = be; v.data = data;
        v.tag = tag; v.req = req; v.exp_cpl = cpl; v.exp_b0 = b0; v.exp_b1 = b1;
        v.exp_k1 = k1; v.exp_led = led_v;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Present one RX beat at a negedge; returns at the negedge after the accepting posedge.
    task automatic rx_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic bar);
        int unsigned n;
        n = 0;
        m_axis_rx_tdata  = d;
        m_axis_rx_tkeep  = k;
        m_axis_rx_tlast  = l;
        m_axis_rx_tuser  = bar ? 22'h000004 : 22'h000000;
        m_axis_rx_tvalid = 1'b1;
        while (!m_axis_rx_tready && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 50) begin
            n_applied++;
            n_miscompares++;
            $display("FAIL rx_tready_wait: got 0 after %0d cycles, want 1", n);
        end
        @(negedge sys_clk);
        m_axis_rx_tvalid = 1'b0;
        m_axis_rx_tlast  = 1'b0;
    endtask

    task automatic send_tlp(input vec_t v);
        rx_beat({v.req, v.tag, 4'h0, v.be, 1'b0, v.ft, 14'h0, v.len}, 8'hFF, 1'b0, v.bar);
        if (v.ft[5]) begin
            if (v.ft[6]) begin
                rx_beat({v.addr, 32'h1}, 8'hFF, 1'b0, 1'b0);
                rx_beat({32'h0, v.data}, 8'h0F, 1'b1, 1'b0);
            end else begin
                rx_beat({v.addr, 32'h1}, 8'hFF, 1'b1, 1'b0);
            end
        end else begin
            if (v.ft[6]) rx_beat({v.data, v.addr}, 8'hFF, 1'b1, 1'b0);
            else         rx_beat({32'h0, v.addr}, 8'h0F, 1'b1, 1'b0);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [63:0] b0, b1;
        logic [7:0]  k0, k1;
        logic        l0, l1, seen;
        int unsigned w;
        send_tlp(v);
        if (v.exp_cpl) begin
            w = 0;
            while (!s_axis_tx_tvalid && w < 50) begin
                @(negedge sys_clk);
                w++;
            end
            b0 = s_axis_tx_tdata; k0 = s_axis_tx_tkeep; l0 = s_axis_tx_tlast;
            @(negedge sys_clk);
            b1 = s_axis_tx_tdata; k1 = s_axis_tx_tkeep; l1 = s_axis_tx_tlast;
            @(negedge sys_clk);
            check({tag, "_latency"}, 64'(w), 64'd1);
            check({tag, "_beat0"}, b0, v.exp_b0);
            check({tag, "_beat1"}, b1, v.exp_b1);
            check({tag, "_keep_last"}, {k0, k1, 6'b0, l0, l1}, {8'hFF, v.exp_k1, 8'h01});
            check({tag, "_idle_after"}, {s_axis_tx_tvalid, m_axis_rx_tready}, 2'b01);
        end else begin
            seen = 1'b0;
            repeat (6) begin
                @(negedge sys_clk);
                if (s_axis_tx_tvalid) seen = 1'b1;
            end
            check({tag, "_no_cpl"}, seen, 1'b0);
        end
        check({tag, "_led"}, led, v.exp_led);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[15];

    initial begin
        logic [63:0] stall_d;
        int unsigned stable, w;

        vecs[0]  = mk(7'h40, 10'd1, 1'b1, 32'h00, 4'hF, 32'h5A000000, 8'h00, 16'h0000, 1'b0, 64'h0, 64'h0, 8'h00, 8'h5A);
        vecs[1]  = mk(7'h00, 10'd1, 1'b1, 32'h00, 4'hF, 32'h0, 8'h01, 16'h0000, 1'b1, CPLD_B0, 64'h5A000000_00000100, 8'hFF, 8'h5A);
        vecs[2]  = mk(7'h00, 10'd1, 1'b1, 32'h1C, 4'hF, 32'h0, 8'h07, 16'h0000, 1'b1, CPLD_B0, 64'h3530434B_0000071C, 8'hFF, 8'h5A);
        vecs[3]  = mk(7'h60, 10'd1, 1'b1, 32'h04, 4'h3, 32'hFFFFFFFF, 8'h00, 16'h0000, 1'b0, 64'h0, 64'h0, 8'h00, 8'h5A);
        vecs[4]  = mk(7'h20, 10'd1, 1'b1, 32'h04, 4'hF, 32'h0, 8'h22, 16'hABCD, 1'b1, CPLD_B0, 64'hFFFF0000_ABCD2204, 8'hFF, 8'h5A);
        vecs[5]  = mk(7'h40, 10'd1, 1'b1, 32'h1C, 4'hF, 32'h11223344, 8'h00, 16'h0000, 1'b0, 64'h0, 64'h0, 8'h00, 8'h5A);
        vecs[6]  = mk(7'h00, 10'd1, 1'b1, 32'h1C, 4'hF, 32'h0, 8'h03, 16'h0000, 1'b1, CPLD_B0, 64'h3530434B_0000031C, 8'hFF, 8'h5A);
        vecs[7]  = mk(7'h40, 10'd1, 1'b1, 32'h28, 4'hA, 32'hAABBCCDD, 8'h00, 16'h0000, 1'b0, 64'h0, 64'h0, 8'h00, 8'h5A);
        vecs[8]  = mk(7'h00, 10'd1, 1'b1, 32'h08, 4'hF, 32'h0, 8'h04, 16'h0102, 1'b1, CPLD_B0, 64'h00BB00DD_01020408, 8'hFF, 8'h5A);
        vecs[9]  = mk(7'h40, 10'd1, 1'b0, 32'h00, 4'hF, 32'hFF000000, 8'h00, 16'h0000, 1'b0, 64'h0, 64'h0, 8'h00, 8'h5A);
        vecs[10] = mk(7'h70, 10'd1, 1'b1, 32'h00, 4'hF, 32'hFF000000, 8'h00, 16'h0000, 1'b0, 64'h0, 64'h0, 8'h00, 8'h5A);
        vecs[11] = mk(7'h00, 10'd2, 1'b1, 32'h00, 4'hF, 32'h0, 8'h09, 16'h0000, UR_BUILD, UR_B0, 64'h00000000_00000900, 8'h0F, 8'h5A);
        vecs[12] = mk(7'h00, 10'd1, 1'b0, 32'h00, 4'hF, 32'h0, 8'h0A, 16'h0000, UR_BUILD, UR_B0, 64'h00000000_00000A00, 8'h0F, 8'h5A);
        vecs[13] = mk(7'h40, 10'd1, 1'b1, 32'h00, 4'h1, 32'h3C000000, 8'h00, 16'h0000, 1'b0, 64'h0, 64'h0, 8'h00, 8'h3C);
        vecs[14] = mk(7'h20, 10'd1, 1'b1, 32'h40, 4'hF, 32'h0, 8'h0B, 16'h0000, 1'b1, CPLD_B0, 64'h3C000000_00000B40, 8'hFF, 8'h3C);

        sys_rst_n        = 1'b0;
        m_axis_rx_tdata  = '0;
        m_axis_rx_tkeep  = '0;
        m_axis_rx_tlast  = 1'b0;
        m_axis_rx_tvalid = 1'b0;
        m_axis_rx_tuser  = '0;
        s_axis_tx_tready = 1'b1;
        cfg_completer_id = 16'h0100;

        repeat (3) @(negedge sys_clk);
        check("reset_ready_valid_last", {m_axis_rx_tready, s_axis_tx_tvalid, s_axis_tx_tlast}, 3'b000);
        check("reset_tdata", s_axis_tx_tdata, 64'h0);
        check("reset_tkeep_led", {s_axis_tx_tkeep, led}, {8'hFF, 8'h00});
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("ready_after_reset", m_axis_rx_tready, 1'b1);

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // TX backpressure: completion must hold while the core is not ready.
        s_axis_tx_tready = 1'b0;
        send_tlp(mk(7'h00, 10'd1, 1'b1, 32'h1C, 4'hF, 32'h0, 8'h55, 16'h0000, 1'b1,
                    CPLD_B0, 64'h0, 8'hFF, 8'h3C));
        w = 0;
        while (!s_axis_tx_tvalid && w < 50) begin
            @(negedge sys_clk);
            w++;
        end
        check("stall_latency", 64'(w), 64'd1);
        stall_d = s_axis_tx_tdata;
        check("stall_beat0", stall_d, CPLD_B0);
        stable = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge sys_clk);
            if (s_axis_tx_tvalid && s_axis_tx_tdata == stall_d && !m_axis_rx_tready) stable++;
        end
        check("stall_stable_cycles", 64'(stable), 64'd10);
        s_axis_tx_tready = 1'b1;
        @(negedge sys_clk);
        check("stall_beat1", s_axis_tx_tdata, 64'h3530434B_0000551C);
        @(negedge sys_clk);
        check("stall_release", {s_axis_tx_tvalid, m_axis_rx_tready}, 2'b01);

        // Reset between write header and payload.
        rx_beat({16'h0000, 8'h00, 4'h0, 4'hF, 1'b0, 7'h40, 14'h0, 10'd1}, 8'hFF, 1'b0, 1'b1);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("midrst_outputs", {m_axis_rx_tready, s_axis_tx_tvalid, led}, 10'h000);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("midrst_ready", m_axis_rx_tready, 1'b1);
        run_vec(mk(7'h00, 10'd1, 1'b1, 32'h00, 4'hF, 32'h0, 8'h60, 16'h0000, 1'b1,
                   CPLD_B0, 64'h00000000_00006000, 8'hFF, 8'h00), "midrst_reg0");
        run_vec(mk(7'h00, 10'd1, 1'b1, 32'h1C, 4'hF, 32'h0, 8'h61, 16'h0000, 1'b1,
                   CPLD_B0, 64'h3530434B_0000611C, 8'hFF, 8'h00), "midrst_id");

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
